// File: rtl/mem_writeback_controller_if.sv
// mem_writeback_controller_if: launch, register-file read and memory write signals of the write-back controller
//   master : controller side (drives strobes, addresses, data, status)
//   slave  : environment side (drives start/base/count, returns register data)
//   start_i, base_addr_i, count_i : launch request and transfer descriptor
//   reg_address_o, reg_rd_en_o, reg_dout_i : register-file sync read port
//   address_o, din_o, we_o : data-memory sync write port
//   state_o, checksum_o, busy_o, done_o : status
interface mem_writeback_controller_if #(
   parameter int MEM_AW = 5,
   parameter int REG_AW = 4,
   parameter int DW     = 8
);
   logic              start_i;
   logic [MEM_AW-1:0] base_addr_i;
   logic [REG_AW:0]   count_i;
   logic [REG_AW-1:0] reg_address_o;
   logic              reg_rd_en_o;
   logic [DW-1:0]     reg_dout_i;
   logic [MEM_AW-1:0] address_o;
   logic [DW-1:0]     din_o;
   logic              we_o;
   logic [2:0]        state_o;
   logic [DW-1:0]     checksum_o;
   logic              busy_o;
   logic              done_o;
   modport master (
      input  start_i, base_addr_i, count_i, reg_dout_i,
      output reg_address_o, reg_rd_en_o, address_o, din_o, we_o,
             state_o, checksum_o, busy_o, done_o
   );
   modport slave (
      output start_i, base_addr_i, count_i, reg_dout_i,
      input  reg_address_o, reg_rd_en_o, address_o, din_o, we_o,
             state_o, checksum_o, busy_o, done_o
   );
endinterface

// File: rtl/mem_writeback_controller.sv
// mem_writeback_controller: copies a block of register-file entries into the 32x8 data memory
//   clk   : system clock, rising edge
//   reset : asynchronous active-high, clears all state and outputs
//   bus   : mem_writeback_controller_if master (launch, reg read port, mem write port, status)
module mem_writeback_controller #(
   parameter int MEM_AW = 5,
   parameter int REG_AW = 4,
   parameter int DW     = 8
) (
   input logic                      clk,
   input logic                      reset,
   mem_writeback_controller_if.master bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [REG_AW:0] MAX_CNT = {1'b1, {REG_AW{1'b0}}};
   logic [2:0]        state_q, state_d;
   logic              start_q;
   logic [MEM_AW-1:0] base_q;
   logic [REG_AW:0]   count_q, count_c;
   logic [REG_AW-1:0] index_q, index_d;
   logic [DW-1:0]     data_q, checksum_q;
   logic [REG_AW-1:0] reg_address_q;
   logic [MEM_AW-1:0] address_q;
   logic              reg_rd_en_q, we_q, done_q;
   logic              launch, last;
   always_comb begin
      count_c = (bus.count_i > MAX_CNT) ? MAX_CNT : bus.count_i;
      launch  = (state_q == S_IDLE) && bus.start_i && !start_q;
      last    = ({1'b0, index_q} + (REG_AW+1)'(1)) == count_q;
      state_d = (state_q == S_IDLE) ? (launch ? ((count_c == '0) ? S_DONE : S_RD) : S_IDLE)
              : (state_q == S_RD)   ? S_WAIT
              : (state_q == S_WAIT) ? S_WR
              : (state_q == S_WR)   ? (last ? S_DONE : S_RD)
              : S_IDLE;
      index_d = launch ? '0 : (state_q == S_WR && !last) ? index_q + 1'b1 : index_q;
   end
   // Strobes are decoded from the next state so each is high exactly while
   // the FSM sits in its state; an async reset drops them at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         start_q       <= 1'b0;
         base_q        <= '0;
         count_q       <= '0;
         index_q       <= '0;
         data_q        <= '0;
         checksum_q    <= '0;
         reg_address_q <= '0;
         address_q     <= '0;
         reg_rd_en_q   <= 1'b0;
         we_q          <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= bus.start_i;
         index_q     <= index_d;
         reg_rd_en_q <= state_d == S_RD;
         we_q        <= state_d == S_WR;
         done_q      <= state_d == S_DONE;
         checksum_q  <= launch ? '0 : (state_q == S_WR) ? checksum_q + data_q : checksum_q;
         if (launch) begin
            base_q  <= bus.base_addr_i;
            count_q <= count_c;
         end
         if (state_q == S_WAIT) data_q <= bus.reg_dout_i;
         if (state_d == S_RD) reg_address_q <= index_d;
         // 5-bit add: addresses past the top of memory wrap to 0
         if (state_d == S_WR) address_q <= base_q + MEM_AW'(index_q);
      end
   end
   assign bus.reg_address_o = reg_address_q;
   assign bus.reg_rd_en_o   = reg_rd_en_q;
   assign bus.address_o     = address_q;
   assign bus.din_o         = data_q;
   assign bus.we_o          = we_q;
   assign bus.state_o       = state_q;
   assign bus.checksum_o    = checksum_q;
   assign bus.busy_o        = state_q inside {S_RD, S_WAIT, S_WR, S_DONE};
   assign bus.done_o        = done_q;
endmodule

// File: tb/tb_mem_writeback_controller.sv
// tb_mem_writeback_controller: directed bench for mem_writeback_controller
module tb_mem_writeback_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   mem_writeback_controller_if bus();
   mem_writeback_controller dut (.clk(clk), .reset(reset), .bus(bus));
   logic [7:0] rf [16];
   logic [7:0] mem [32];
   always @(posedge clk) begin
      if (bus.reg_rd_en_o) bus.reg_dout_i <= rf[bus.reg_address_o];
      if (bus.we_o) mem[bus.address_o] <= bus.din_o;
   end
   int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   logic [4:0] wr_log [256];
   logic [3:0] rd_log [256];
   always @(negedge clk) begin
      if (bus.we_o) begin
         wr_log[8'(wr_cnt)] = bus.address_o;
         wr_cnt++;
      end
      if (bus.reg_rd_en_o) begin
         rd_log[8'(rd_cnt)] = bus.reg_address_o;
         rd_cnt++;
      end
      if (bus.done_o) done_cnt++;
   end
   int total = 0, bad = 0;
   int w0, r0, d0, lat, nwe, errs;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_done(output int l);
      l = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (bus.done_o) begin
            l = c;
            break;
         end
      end
   endtask
   task automatic launch(input logic [4:0] b, input logic [4:0] n);
      @(negedge clk);
      bus.start_i = 1'b0;
      w0 = wr_cnt;
      r0 = rd_cnt;
      d0 = done_cnt;
      @(negedge clk);
      bus.base_addr_i = b;
      bus.count_i = n;
      bus.start_i = 1'b1;
   endtask
   initial begin
      bus.start_i = 1'b1;
      bus.base_addr_i = 5'd0;
      bus.count_i = 5'd4;
      bus.reg_dout_i = 8'h00;
      for (int i = 0; i < 16; i++) rf[i] = 8'(i + 1);
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      // T1: start held high across reset release launches exactly one run
      #2;
      chk("rst_state", bus.state_o, 0);
      chk("rst_we", bus.we_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_cksum", bus.checksum_o, 0);
      chk("rst_rden", bus.reg_rd_en_o, 0);
      #8 reset = 1'b0;
      w0 = 0; r0 = 0; d0 = 0;
      @(posedge clk);
      wait_done(lat);
      chk("t1_latency", lat, 13);
      repeat (20) @(negedge clk);
      chk("t1_writes", wr_cnt - w0, 4);
      chk("t1_reads", rd_cnt - r0, 4);
      chk("t1_dones", done_cnt - d0, 1);
      chk("t1_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h04030201);
      chk("t1_cksum", bus.checksum_o, 8'h0A);
      chk("t1_idle", bus.state_o, 0);
      // T2: address wrap past 31
      for (int i = 0; i < 4; i++) rf[i] = 8'(8'h80 + i);
      launch(5'd30, 5'd4);
      wait_done(lat);
      chk("t2_latency", lat, 13);
      repeat (3) @(negedge clk);
      chk("t2_writes", wr_cnt - w0, 4);
      chk("t2_addrs", {wr_log[8'(w0)], wr_log[8'(w0+1)], wr_log[8'(w0+2)], wr_log[8'(w0+3)]}, {5'd30, 5'd31, 5'd0, 5'd1});
      chk("t2_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'h80818283);
      chk("t2_cksum", bus.checksum_o, 8'h06);
      chk("t2_dones", done_cnt - d0, 1);
      // T3: zero-length transfer
      launch(5'd7, 5'd0);
      wait_done(lat);
      chk("t3_latency", lat, 1);
      repeat (3) @(negedge clk);
      chk("t3_reads", rd_cnt - r0, 0);
      chk("t3_writes", wr_cnt - w0, 0);
      chk("t3_cksum", bus.checksum_o, 0);
      chk("t3_dones", done_cnt - d0, 1);
      // T4: count 20 clamps to 16
      for (int i = 0; i < 16; i++) rf[i] = 8'(3 * i + 5);
      launch(5'd5, 5'd20);
      wait_done(lat);
      chk("t4_latency", lat, 49);
      repeat (3) @(negedge clk);
      chk("t4_writes", wr_cnt - w0, 16);
      chk("t4_reads", rd_cnt - r0, 16);
      errs = 0;
      for (int i = 0; i < 16; i++) if (rd_log[8'(r0 + i)] !== 4'(i)) errs++;
      chk("t4_rdaddr_seq", errs, 0);
      chk("t4_mem", {mem[5], mem[20]}, {8'd5, 8'd50});
      chk("t4_cksum", bus.checksum_o, 8'hB8);
      // T5: reset during the second write abandons the word
      for (int i = 0; i < 8; i++) rf[i] = 8'(8'h40 + i);
      launch(5'd0, 5'd8);
      nwe = 0;
      for (int c = 0; c < 100 && nwe < 2; c++) begin
         @(negedge clk);
         if (bus.we_o) nwe++;
      end
      chk("t5_reached_wr2", nwe, 2);
      reset = 1'b1;
      bus.start_i = 1'b0;
      #1;
      chk("t5_we_drop", bus.we_o, 0);
      chk("t5_state", bus.state_o, 0);
      chk("t5_cksum", bus.checksum_o, 0);
      chk("t5_busy", bus.busy_o, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_idle", bus.state_o, 0);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_mem", {mem[0], mem[1]}, 16'h4083);
      for (int i = 0; i < 8; i++) rf[i] = 8'(8'h10 + i);
      launch(5'd8, 5'd8);
      wait_done(lat);
      chk("t5_latency", lat, 25);
      repeat (3) @(negedge clk);
      chk("t5_writes", wr_cnt - w0, 8);
      chk("t5_mem2", {mem[8], mem[15]}, 16'h1017);
      chk("t5_cksum2", bus.checksum_o, 8'h9C);
      // T6: start pulses while busy are ignored
      launch(5'd20, 5'd5);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         bus.start_i = (c == 1 || c == 4 || c == 10);
         if (bus.done_o) begin
            lat = c;
            break;
         end
      end
      chk("t6_latency", lat, 16);
      repeat (10) @(negedge clk);
      chk("t6_writes", wr_cnt - w0, 5);
      chk("t6_reads", rd_cnt - r0, 5);
      chk("t6_dones", done_cnt - d0, 1);
      chk("t6_cksum", bus.checksum_o, 8'h5A);
      chk("t6_mem", {mem[20], mem[24]}, 16'h1014);
      chk("t6_idle", bus.state_o, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
